// File: rtl/priority_encoder_pipe.sv
// Registered N-bit priority encoder with a valid/ack output hold.
// Define PRIO_RR_EN to compile in rotating (round-robin) priority.
module priority_encoder_pipe #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] I,
  input  logic         ack,
  output logic [W-1:0] F,
  output logic         valid,
  output logic         multi
);

  logic         load;
  logic         hit;
  logic         many;
  logic [W-1:0] win;

  assign load = !valid || ack;
  assign hit  = en && (|I);
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign many = |(I & (I - N'(1)));

`ifdef PRIO_RR_EN
  logic [W-1:0] ptr;

  function automatic int unsigned rr_idx(input logic [W-1:0] p, input int unsigned j);
    int unsigned s;
    s = int'(p) + 1 + j;
    return (s >= unsigned'(N)) ? s - unsigned'(N) : s;
  endfunction

  // Scan from ptr+1 up around to ptr; later hits override, so ptr wins.
  always_comb begin
    win = '0;
    for (int unsigned j = 0; j < unsigned'(N); j++) begin
      if (|(I & (N'(1) << rr_idx(ptr, j)))) win = W'(rr_idx(ptr, j));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= W'(N - 1);
    end else if (load && hit) begin
      ptr <= (win == '0) ? W'(N - 1) : win - W'(1);
    end
  end
`else
  always_comb begin
    win = '0;
    for (int unsigned j = 0; j < unsigned'(N); j++) begin
      if (|(I & (N'(1) << j))) win = W'(j);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F     <= '0;
      valid <= 1'b0;
      multi <= 1'b0;
    end else if (load) begin
      if (hit) begin
        F     <= win;
        valid <= 1'b1;
        multi <= many;
      end else begin
        valid <= 1'b0;
        multi <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_priority_encoder_pipe.sv
// Directed bench for priority_encoder_pipe (N=8) with a cycle-level reference model.
// Honours PRIO_RR_EN the same way the design does.
module tb_priority_encoder_pipe;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [N-1:0] I = '0;
  logic         ack = 1'b0;
  logic [W-1:0] F;
  logic         valid;
  logic         multi;

  int tests = 0;
  int fails = 0;

  priority_encoder_pipe #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .I(I), .ack(ack),
    .F(F), .valid(valid), .multi(multi)
  );

  always #5 clk = ~clk;

  // Reference model: plain search over the request word in priority order.
  int m_F = 0;
  int m_valid = 0;
  int m_multi = 0;
  int m_ptr = N - 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_F = 0; m_valid = 0; m_multi = 0; m_ptr = N - 1;
    end else if (m_valid == 0 || ack) begin
      if (en && I != 0) begin
        int g;
        int found;
        g = 0;
        found = 0;
        for (int s = 0; s < N; s++) begin
          int k;
`ifdef PRIO_RR_EN
          k = (m_ptr - s + N) % N;
`else
          k = N - 1 - s;
`endif
          if (!found && I[k]) begin
            g = k;
            found = 1;
          end
        end
        m_F = g;
        m_valid = 1;
        m_multi = ($countones(I) >= 2) ? 1 : 0;
        m_ptr = (g == 0) ? N - 1 : g - 1;
      end else begin
        m_valid = 0;
        m_multi = 0;
      end
    end
  end

  always @(negedge clk) begin
    tests++;
    if (F !== W'(m_F) || valid !== 1'(m_valid) || multi !== 1'(m_multi)) begin
      fails++;
      $display("FAIL model t=%0t F=%0d valid=%0d multi=%0d required F=%0d valid=%0d multi=%0d",
               $time, F, valid, multi, m_F, m_valid, m_multi);
    end
  end

  task automatic check(input string name, input logic [W-1:0] f_exp,
                       input logic v_exp, input logic m_exp);
    tests++;
    if (F !== f_exp || valid !== v_exp || multi !== m_exp) begin
      fails++;
      $display("FAIL %s F=%0d valid=%0d multi=%0d required F=%0d valid=%0d multi=%0d",
               name, F, valid, multi, f_exp, v_exp, m_exp);
    end
  endtask

  task automatic step(input logic e, input logic [N-1:0] i, input logic a);
    en = e; I = i; ack = a;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous pulse between edges; outputs must clear before any edge.
  task automatic pulse_reset(input string name);
    #2 rst_n = 1'b0;
    #1 check(name, '0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
  endtask

  logic [W-1:0] rr_exp [0:8];

  initial begin
`ifdef PRIO_RR_EN
    rr_exp = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
`else
    rr_exp = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif
    en = 1'b1; I = 8'hFF; ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("reset_hold", 3'd0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    step(1'b1, 8'hFF, 1'b0);          check("first_after_reset", 3'd7, 1'b1, 1'b1);
    step(1'b1, 8'b0000_0001, 1'b1);   check("enc_bit0", 3'd0, 1'b1, 1'b0);
    step(1'b1, 8'b1010_1110, 1'b1);   check("enc_ae", 3'd7, 1'b1, 1'b1);
    step(1'b1, 8'b0001_0000, 1'b1);   check("enc_bit4", 3'd4, 1'b1, 1'b0);

    pulse_reset("reset_before_hold");
    step(1'b1, 8'b0010_1110, 1'b1);   check("hold_capture", 3'd5, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 8'b0000_0100, 1'b0); check("hold_frozen", 3'd5, 1'b1, 1'b1);
    end
    step(1'b0, 8'h00, 1'b0);          check("hold_frozen_en0", 3'd5, 1'b1, 1'b1);
    step(1'b1, 8'b0000_0100, 1'b1);   check("accept_next", 3'd2, 1'b1, 1'b0);

    step(1'b0, 8'hFF, 1'b1);          check("disable", 3'd2, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b1);          check("empty", 3'd2, 1'b0, 1'b0);
    step(1'b1, 8'b0100_0000, 1'b0);   check("capture_idle", 3'd6, 1'b1, 1'b0);

    pulse_reset("reset_before_rotate");
    for (int c = 0; c < 9; c++) begin
      step(1'b1, 8'hFF, 1'b1);        check("rotate_ff", rr_exp[c], 1'b1, 1'b1);
    end

    pulse_reset("reset_before_midop");
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 8'hFF, 1'b1);
    end
    check("midop_before", rr_exp[3], 1'b1, 1'b1);
    pulse_reset("midop_async_clear");
    step(1'b1, 8'hFF, 1'b1);          check("midop_after_release", 3'd7, 1'b1, 1'b1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout tests=%0d required completion", tests);
    $fatal(1);
  end

endmodule
